// File: rtl/receive_fsm_if.sv
// Signal bundle between a UART receive pin/config source and the receive_fsm.
// master drives the serial line, oversample tick and line control; slave is the receiver.
interface receive_fsm_if;
  logic       urrst;
  logic       rxd;
  logic       rx_tick;
  logic [1:0] wls;
  logic       pen;
  logic       eps;
  logic       sp;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       pe;
  logic       fe;
  logic       bi;
  logic       rx_busy;

  modport master (
    output urrst, rxd, rx_tick, wls, pen, eps, sp,
    input  rx_data, rx_valid, pe, fe, bi, rx_busy
  );

  modport slave (
    input  urrst, rxd, rx_tick, wls, pen, eps, sp,
    output rx_data, rx_valid, pe, fe, bi, rx_busy
  );
endinterface

// File: rtl/receive_fsm.sv
// UART receiver: synchronizes rxd, finds the start bit, samples each bit at mid-bit
// and reports the character with parity, framing and break status.
module receive_fsm #(
  parameter int OSR         = 16,
  parameter int SYNC_STAGES = 2
) (
  input logic          pclk,
  input logic          presetn,
  receive_fsm_if.slave bus
);

  localparam int CW = $clog2(OSR);
  localparam logic [CW-1:0] HALF_M1 = CW'(OSR / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(OSR - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_START    = 3'd1,
    S_DATA     = 3'd2,
    S_PARITY   = 3'd3,
    S_STOP     = 3'd4,
    S_BRK_WAIT = 3'd5
  } state_t;

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          sample_cnt_q;
  logic [2:0]             bit_cnt_q;
  logic [7:0]             data_q;
  logic                   rpar_q;
  logic [7:0]             rx_data_q;
  logic                   rx_valid_q;
  logic                   pe_q;
  logic                   fe_q;
  logic                   bi_q;
  logic                   busy_q;

  logic                   rxs_s;
  logic [2:0]             last_bit_s;
  logic                   half_pt_s;
  logic                   full_pt_s;
  logic                   exp_par_s;

  // Expected parity: stick parity forces ~eps, otherwise even/odd over the data bits.
  function automatic logic parity_expected(input logic [7:0] d, input logic stick, input logic even);
    logic x;
    x = ^d;
    if (stick) begin
      return ~even;
    end else begin
      return even ? x : ~x;
    end
  endfunction

  assign rxs_s      = sync_q[SYNC_STAGES-1];
  // Index of the last data bit is wordlen-1 = 4 + wls.
  assign last_bit_s = {1'b1, bus.wls};
  assign half_pt_s  = (sample_cnt_q == HALF_M1);
  assign full_pt_s  = (sample_cnt_q == FULL_M1);
  assign exp_par_s  = parity_expected(data_q, bus.sp, bus.eps);

  // rxd metastability synchronizer, resets to the idle level.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.rxd};
    end
  end

  // Receive FSM with counters, character assembly and registered status outputs.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q      <= S_IDLE;
      sample_cnt_q <= '0;
      bit_cnt_q    <= 3'd0;
      data_q       <= 8'h00;
      rpar_q       <= 1'b0;
      rx_data_q    <= 8'h00;
      rx_valid_q   <= 1'b0;
      pe_q         <= 1'b0;
      fe_q         <= 1'b0;
      bi_q         <= 1'b0;
      busy_q       <= 1'b0;
    end else if (!bus.urrst) begin
      state_q      <= S_IDLE;
      sample_cnt_q <= '0;
      bit_cnt_q    <= 3'd0;
      data_q       <= 8'h00;
      rpar_q       <= 1'b0;
      rx_data_q    <= 8'h00;
      rx_valid_q   <= 1'b0;
      pe_q         <= 1'b0;
      fe_q         <= 1'b0;
      bi_q         <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!rxs_s) begin
            state_q      <= S_START;
            sample_cnt_q <= '0;
            busy_q       <= 1'b1;
          end
        end
        S_START: begin
          if (bus.rx_tick) begin
            if (half_pt_s) begin
              sample_cnt_q <= '0;
              if (!rxs_s) begin
                state_q   <= S_DATA;
                bit_cnt_q <= 3'd0;
                data_q    <= 8'h00;
                rpar_q    <= 1'b0;
              end else begin
                // Line went back high before mid-start: a glitch, not a frame.
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              sample_cnt_q <= sample_cnt_q + CW'(1);
            end
          end
        end
        S_DATA: begin
          if (bus.rx_tick) begin
            if (full_pt_s) begin
              data_q[bit_cnt_q] <= rxs_s;
              sample_cnt_q      <= '0;
              if (bit_cnt_q == last_bit_s) begin
                state_q <= bus.pen ? S_PARITY : S_STOP;
              end else begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
              end
            end else begin
              sample_cnt_q <= sample_cnt_q + CW'(1);
            end
          end
        end
        S_PARITY: begin
          if (bus.rx_tick) begin
            if (full_pt_s) begin
              rpar_q       <= rxs_s;
              sample_cnt_q <= '0;
              state_q      <= S_STOP;
            end else begin
              sample_cnt_q <= sample_cnt_q + CW'(1);
            end
          end
        end
        S_STOP: begin
          if (bus.rx_tick) begin
            if (full_pt_s) begin
              sample_cnt_q <= '0;
              rx_valid_q   <= 1'b1;
              rx_data_q    <= data_q;
              pe_q         <= bus.pen & (rpar_q != exp_par_s);
              fe_q         <= ~rxs_s;
              bi_q         <= ~rxs_s & (data_q == 8'h00) & (~bus.pen | ~rpar_q);
              if (rxs_s) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
              end else begin
                state_q <= S_BRK_WAIT;
              end
            end else begin
              sample_cnt_q <= sample_cnt_q + CW'(1);
            end
          end
        end
        S_BRK_WAIT: begin
          if (rxs_s) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q      <= S_IDLE;
          sample_cnt_q <= '0;
          bit_cnt_q    <= 3'd0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.pe       = pe_q;
  assign bus.fe       = fe_q;
  assign bus.bi       = bi_q;
  assign bus.rx_busy  = busy_q;

endmodule

// File: tb/tb_receive_fsm.sv
// Scoreboard bench for receive_fsm: directed frames push expected characters,
// a monitor pops and compares on every rx_valid.
module tb_receive_fsm;
  localparam int OSR = 16;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    logic       bi;
  } exp_t;

  logic pclk    = 1'b0;
  logic presetn = 1'b0;
  int   cyc     = 0;
  int   checks  = 0;
  int   errors  = 0;
  int   fall_cyc  = 0;
  int   valid_cyc = 0;
  exp_t sb[$];

  receive_fsm_if bus ();

  receive_fsm #(.OSR(OSR), .SYNC_STAGES(2)) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .bus     (bus)
  );

  always #5 pclk = ~pclk;

  always @(posedge pclk) cyc <= cyc + 1;

  // Oversample tick: high every other pclk cycle.
  initial begin
    bus.rx_tick = 1'b0;
    forever begin
      @(negedge pclk);
      bus.rx_tick = ~bus.rx_tick;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(negedge pclk) begin : monitor
    exp_t e;
    if (bus.rx_valid === 1'b1) begin
      valid_cyc = cyc;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got rx_valid with data %0h, expected none", bus.rx_data);
      end else begin
        e = sb.pop_front();
        chk("rx_data", {24'd0, bus.rx_data}, {24'd0, e.d});
        chk("pe", {31'd0, bus.pe}, {31'd0, e.pe});
        chk("fe", {31'd0, bus.fe}, {31'd0, e.fe});
        chk("bi", {31'd0, bus.bi}, {31'd0, e.bi});
      end
    end
  end

  task automatic wait_ticks(input int n);
    repeat (2 * n) @(negedge pclk);
  endtask

  task automatic expect_char(input logic [7:0] d, input logic pe, input logic fe, input logic bi);
    exp_t e;
    e.d  = d;
    e.pe = pe;
    e.fe = fe;
    e.bi = bi;
    sb.push_back(e);
  endtask

  task automatic send_frame(input logic [7:0] d, input int nbits, input bit par_en,
                            input bit par, input bit stop);
    bus.rxd  = 1'b0;
    fall_cyc = cyc;
    wait_ticks(OSR);
    for (int i = 0; i < nbits; i++) begin
      bus.rxd = d[i];
      wait_ticks(OSR);
    end
    if (par_en) begin
      bus.rxd = par;
      wait_ticks(OSR);
    end
    bus.rxd = stop;
    wait_ticks(OSR);
  endtask

  initial begin
    int  lat;
    logic [7:0] part;
    bus.rxd   = 1'b1;
    bus.urrst = 1'b1;
    bus.wls   = 2'b11;
    bus.pen   = 1'b0;
    bus.eps   = 1'b0;
    bus.sp    = 1'b0;
    repeat (3) @(negedge pclk);
    chk("reset_rx_data", {24'd0, bus.rx_data}, 32'h0);
    chk("reset_rx_valid", {31'd0, bus.rx_valid}, 32'h0);
    chk("reset_rx_busy", {31'd0, bus.rx_busy}, 32'h0);
    chk("reset_flags", {29'd0, bus.pe, bus.fe, bus.bi}, 32'h0);
    presetn = 1'b1;
    wait_ticks(4);

    // 8N1 0xA5 with latency check: 152 ticks (2 pclk each) plus sync and entry cycles.
    expect_char(8'hA5, 1'b0, 1'b0, 1'b0);
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1);
    wait_ticks(4);
    lat = valid_cyc - fall_cyc;
    chk("latency_window", {31'd0, (lat >= 305 && lat <= 308)}, 32'h1);

    // Short low glitch on an idle line.
    bus.rxd = 1'b0;
    wait_ticks(4);
    bus.rxd = 1'b1;
    chk("glitch_busy_high", {31'd0, bus.rx_busy}, 32'h1);
    wait_ticks(8);
    chk("glitch_busy_low", {31'd0, bus.rx_busy}, 32'h0);
    wait_ticks(8);

    // 7E1 0x41: two ones so the even parity bit should be 0.
    bus.wls = 2'b10;
    bus.pen = 1'b1;
    bus.eps = 1'b1;
    expect_char(8'h41, 1'b1, 1'b0, 1'b0);
    send_frame(8'h41, 7, 1'b1, 1'b1, 1'b1);
    wait_ticks(4);
    expect_char(8'h41, 1'b0, 1'b0, 1'b0);
    send_frame(8'h41, 7, 1'b1, 1'b0, 1'b1);
    wait_ticks(4);

    // 8N1 0x3C with a low stop bit: framing error, receiver parks until line high.
    bus.wls = 2'b11;
    bus.pen = 1'b0;
    bus.eps = 1'b0;
    expect_char(8'h3C, 1'b0, 1'b1, 1'b0);
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0);
    chk("brkwait_busy", {31'd0, bus.rx_busy}, 32'h1);
    bus.rxd = 1'b1;
    wait_ticks(4);
    chk("brkwait_exit", {31'd0, bus.rx_busy}, 32'h0);

    // 8E1 line held low for 20 bit times: one break character only.
    bus.pen = 1'b1;
    bus.eps = 1'b1;
    expect_char(8'h00, 1'b0, 1'b1, 1'b1);
    bus.rxd = 1'b0;
    wait_ticks(20 * OSR);
    chk("break_busy", {31'd0, bus.rx_busy}, 32'h1);
    bus.rxd = 1'b1;
    wait_ticks(4);
    chk("break_exit", {31'd0, bus.rx_busy}, 32'h0);
    expect_char(8'h55, 1'b0, 1'b0, 1'b0);
    send_frame(8'h55, 8, 1'b1, 1'b0, 1'b1);
    wait_ticks(4);

    // urrst drop in the middle of the 4th data bit (8N1).
    bus.pen = 1'b0;
    bus.eps = 1'b0;
    part = 8'h0F;
    bus.rxd = 1'b0;
    wait_ticks(OSR);
    for (int i = 0; i < 3; i++) begin
      bus.rxd = part[i];
      wait_ticks(OSR);
    end
    bus.rxd = part[3];
    wait_ticks(OSR / 2);
    chk("abort_busy_before", {31'd0, bus.rx_busy}, 32'h1);
    bus.urrst = 1'b0;
    @(negedge pclk);
    chk("abort_rx_data", {24'd0, bus.rx_data}, 32'h0);
    chk("abort_busy", {31'd0, bus.rx_busy}, 32'h0);
    bus.rxd = 1'b1;
    wait_ticks(4);
    bus.urrst = 1'b1;
    wait_ticks(4);

    // 5N1 back-to-back frames; only 5 bits of each go on the wire.
    bus.wls = 2'b00;
    expect_char(8'h12, 1'b0, 1'b0, 1'b0);
    expect_char(8'h14, 1'b0, 1'b0, 1'b0);
    send_frame(8'h12, 5, 1'b0, 1'b0, 1'b1);
    send_frame(8'h34, 5, 1'b0, 1'b0, 1'b1);
    bus.rxd = 1'b1;
    wait_ticks(4);

    // Stick parity with 8-bit 0xFF and parity bit 1.
    bus.wls = 2'b11;
    bus.pen = 1'b1;
    bus.sp  = 1'b1;
    bus.eps = 1'b0;
    expect_char(8'hFF, 1'b0, 1'b0, 1'b0);
    send_frame(8'hFF, 8, 1'b1, 1'b1, 1'b1);
    wait_ticks(4);
    bus.eps = 1'b1;
    expect_char(8'hFF, 1'b1, 1'b0, 1'b0);
    send_frame(8'hFF, 8, 1'b1, 1'b1, 1'b1);
    wait_ticks(4);

    chk("scoreboard_drained", sb.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/receive_fsm.md
Name: receive_fsm

Overview:
- UART receiver control and datapath: oversamples the serial input `rxd` and finds the start bit.
- Samples data, parity and stop bits at mid-bit, assembles the character and flags parity, framing and break errors.
- Counterpart to the transmit path; sits between the receive pin and the receiver buffer / line-status logic.
- Baud generation is external and arrives as a 1-pclk-wide `rx_tick` enable at OSR × baud.

Parameters:
- OSR, 16, oversample ticks per bit; must be even and ≥ 4.
- SYNC_STAGES, 2, flops in the rxd metastability synchronizer.

Ports:
- pclk  input  1  system clock
- presetn  input  1  asynchronous active-low reset
- urrst  input  1  receiver enable; 0 holds receiver in reset (synchronous)
- rxd  input  1  serial input; idle high
- rx_tick  input  1  oversample enable, OSR per bit period
- wls  input  2  word length: 00=5, 01=6, 10=7, 11=8 bits
- pen  input  1  parity enable
- eps  input  1  even parity select (1 = even)
- sp  input  1  stick parity
- rx_data  output  8  received character, LSB-aligned; unused upper bits 0
- rx_valid  output  1  one-pclk pulse, character complete
- pe  output  1  parity error for the character in rx_data
- fe  output  1  framing error (first stop bit sampled 0)
- bi  output  1  break: data, parity (if enabled) and stop all 0
- rx_busy  output  1  high in every state except IDLE

Behaviour:
- Reset values: rx_data=0, rx_valid=0, pe=fe=bi=0, state=IDLE, counters=0, synchronizer flops=1.
- Synchronizer: rxd passes through SYNC_STAGES flops; all FSM decisions use the synchronized value (rxs).
- urrst=0: next pclk forces IDLE, clears counters and all outputs; overrides every event in flight, including mid-frame.
- Counters: sample_cnt (log2(OSR) bits) advances only on rx_tick; bit_cnt is 3 bits.
- States:
  - IDLE: rxs==0 → START, sample_cnt=0.
  - START: on rx_tick, if sample_cnt==OSR/2-1, test rxs: rxs==0 → DATA with sample_cnt=0, bit_cnt=0; rxs==1 → IDLE (false start, no rx_valid). Otherwise sample_cnt++.
  - DATA: on rx_tick, if sample_cnt==OSR-1, sample rxs into data bit bit_cnt and set sample_cnt=0. If bit_cnt==wordlen-1 → PARITY when pen, else STOP. Otherwise bit_cnt++. Otherwise sample_cnt++.
  - PARITY: same timing as DATA, sampled bit stored as rpar → STOP.
  - STOP: same timing, sample stop bit. Raise rx_valid next pclk and update rx_data/pe/fe/bi together. rxs==1 → IDLE; rxs==0 → BRK_WAIT.
  - BRK_WAIT: stay until rxs==1, then IDLE. No new start detection while in BRK_WAIT.
- Sample points fall at mid-bit: start at OSR/2 ticks after the falling edge, then every OSR ticks.
- Parity, expected bit:
  - sp=0: eps=1 → XOR of data bits; eps=0 → its inverse.
  - sp=1: expected = ~eps.
  - pe = pen & (rpar != expected); pen=0 → pe=0.
- fe=1 when the stop sample is 0.
- bi=1 when all data bits, rpar (if pen) and the stop bit are 0; fe is also 1 in this case.
- Only the first stop bit is checked. A new start can be detected in the pclk cycle after returning to IDLE.
- Output hold: rx_data/pe/fe/bi update only with rx_valid and hold until the next rx_valid, or urrst/presetn.
- wls/pen/eps/sp are sampled live; software changes them only while rx_busy=0, so behaviour mid-frame is undefined.
- rx_tick held low freezes the FSM with no timeout.
- rxd glitches shorter than OSR/2 ticks inside START are rejected.

Test Plan:
- 8N1 (wls=11, pen=0), OSR=16, serial 0xA5 LSB-first → one rx_valid; rx_data=0xA5, pe=fe=bi=0; rx_valid occurs 9.5 bit periods (152 ticks) after the falling edge, +SYNC_STAGES+1 pclk.
- Low pulse of 4 ticks on idle line → START entered, returns to IDLE at tick 7; no rx_valid; rx_busy pulses high then low.
- 7E1 (wls=10, pen=1, eps=1), data 0x41 with parity bit 1 (wrong) → rx_data=0x41, pe=1, fe=0; repeat with parity 0 → pe=0.
- 8N1, 0x3C with stop bit 0, then line high → rx_data=0x3C, fe=1, bi=0; FSM passes BRK_WAIT then IDLE.
- Line held low for 20 bit times, 8E1 → one rx_valid only, rx_data=0x00, fe=1, bi=1; remains in BRK_WAIT until rxd=1; then a 0x55 frame is received correctly.
- urrst dropped at the 4th data bit → next pclk state=IDLE, rx_data=0, no rx_valid. Then urrst=1 with back-to-back 0x12, 0x34 (5N1, wls=00) → rx_data=0x12 then 0x14 (upper bits masked to 5-bit word).
- Stick parity: sp=1, eps=0, pen=1, 8-bit 0xFF with parity bit 1 → pe=0; same frame with eps=1 → pe=1.
